// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and instruction memory (slave).
// A word read is requested with req/addr and is completed by ack/rdata.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, issues imem reads, and fills IF/ID through a 1-entry skid buffer.
// Define MISALIGN_TRAP_EN to trap misaligned redirect targets and add the fetch_misalign output.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [5:0]          ifid_opcode,
  output logic [ADDR_W-1:0]   ifid_pc4
`ifdef MISALIGN_TRAP_EN
  , output logic              fetch_misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_FULL} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] redir_reg;
  logic              imem_req_reg;
  logic              ifid_valid_reg;
  logic [31:0]       ifid_instr_reg;
  logic [ADDR_W-1:0] ifid_pc4_reg;
  logic [31:0]       skid_instr_reg;
  logic [ADDR_W-1:0] skid_pc4_reg;

  logic              accept;
  logic              trap_hit;
  logic              halted;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] pc_plus4;

  assign accept    = !ifid_valid_reg || !stall;
  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_plus4  = pc_reg + ADDR_W'(4);

`ifdef MISALIGN_TRAP_EN
  logic misalign_reg;
  assign trap_hit       = redirect && (redirect_pc[1:0] != 2'b00);
  assign halted         = misalign_reg;
  assign fetch_misalign = misalign_reg;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign trap_hit            = 1'b0;
  assign halted              = 1'b0;
`endif

  assign imem.req    = imem_req_reg;
  assign imem.addr   = pc_reg;
  assign ifid_valid  = ifid_valid_reg;
  assign ifid_instr  = ifid_instr_reg;
  assign ifid_opcode = ifid_instr_reg[31:26];
  assign ifid_pc4    = ifid_pc4_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      pc_reg         <= RESET_PC[ADDR_W-1:0];
      redir_reg      <= '0;
      imem_req_reg   <= 1'b0;
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= '0;
      ifid_pc4_reg   <= '0;
      skid_instr_reg <= '0;
      skid_pc4_reg   <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_reg   <= 1'b0;
`endif
    end else if (redirect) begin
      // Redirect outranks stall and ack: whatever IF/ID or the skid holds is wrong-path.
      ifid_valid_reg <= 1'b0;
      if (trap_hit) begin
        state_reg    <= S_IDLE;
        imem_req_reg <= 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_reg <= 1'b1;
`endif
      end else begin
`ifdef MISALIGN_TRAP_EN
        misalign_reg <= 1'b0;
`endif
        case (state_reg)
          S_REQ: begin
            if (imem.ack) begin
              pc_reg <= target_pc;
            end else begin
              redir_reg <= target_pc;
              state_reg <= S_DROP;
            end
          end
          S_DROP: begin
            if (imem.ack) begin
              pc_reg    <= target_pc;
              state_reg <= S_REQ;
            end else begin
              redir_reg <= target_pc;
            end
          end
          default: begin
            pc_reg       <= target_pc;
            state_reg    <= S_REQ;
            imem_req_reg <= 1'b1;
          end
        endcase
      end
    end else begin
      // Bubble unless IF/ID is being held; any load below overrides this.
      if (!(stall && ifid_valid_reg)) begin
        ifid_valid_reg <= 1'b0;
      end
      case (state_reg)
        S_IDLE: begin
          if (!halted) begin
            state_reg    <= S_REQ;
            imem_req_reg <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem.ack) begin
            pc_reg <= pc_plus4;
            if (accept) begin
              ifid_valid_reg <= 1'b1;
              ifid_instr_reg <= imem.rdata;
              ifid_pc4_reg   <= pc_plus4;
            end else begin
              skid_instr_reg <= imem.rdata;
              skid_pc4_reg   <= pc_plus4;
              state_reg      <= S_FULL;
              imem_req_reg   <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (imem.ack) begin
            pc_reg    <= redir_reg;
            state_reg <= S_REQ;
          end
        end
        S_FULL: begin
          if (!stall) begin
            ifid_valid_reg <= 1'b1;
            ifid_instr_reg <= skid_instr_reg;
            ifid_pc4_reg   <= skid_pc4_reg;
            state_reg      <= S_REQ;
            imem_req_reg   <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
